// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl
//   Issue controller between the FP decode stage and an fpnew-based FP unit.
//   Decoded operations wait in a DEPTH-entry in-order queue. The head is
//   offered to the FPU only when none of its used sources and (if it writes)
//   its destination are pending in the 32-entry scoreboard, and a tag is free.
//   Completing tags are mapped back to the destination register / write enable.
//
// Optional feature (macro FP_ISSUE_CMP_BYPASS_EN):
//   Defined   - a completion in the current cycle is forwarded into the issue
//               check (its tag counts as free, its rd as not pending).
//   Undefined - the issue check only sees registered scoreboard / tag state.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   in_valid_i / in_ready_o        decode-side push handshake
//   in_rs_i, in_rs_use_i           {rs3,rs2,rs1} and per-source read flags
//   in_rd_i, in_rd_we_i            destination register and write flag
//   in_payload_i                   opaque operation bits
//   flush_i                        drop queued, not-yet-issued operations
//   iss_valid_o / iss_ready_i      FPU issue handshake
//   iss_payload_o, iss_tag_o       head payload and allocated tag
//   cmp_valid_i, cmp_tag_i         FPU result handshake and its tag
//   cmp_rd_o, cmp_we_o             register file write port (combinational)
//   count_o, inflight_o, busy_o    occupancy status
module fp_issue_ctrl #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 64,
  parameter int TAG_W     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [14:0]            in_rs_i,
  input  logic [2:0]             in_rs_use_i,
  input  logic [4:0]             in_rd_i,
  input  logic                   in_rd_we_i,
  input  logic [PAYLOAD_W-1:0]   in_payload_i,
  input  logic                   flush_i,
  output logic                   iss_valid_o,
  input  logic                   iss_ready_i,
  output logic [PAYLOAD_W-1:0]   iss_payload_o,
  output logic [TAG_W-1:0]       iss_tag_o,
  input  logic                   cmp_valid_i,
  input  logic [TAG_W-1:0]       cmp_tag_i,
  output logic [4:0]             cmp_rd_o,
  output logic                   cmp_we_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [TAG_W:0]         inflight_o,
  output logic                   busy_o
);

  localparam int MAXF  = 1 << TAG_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [14:0]          rs;
    logic [2:0]           rs_use;
    logic [4:0]           rd;
    logic                 rd_we;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0]      sb, sb_next, sb_view;
  logic [MAXF-1:0]  tag_valid, tag_valid_next, free_view;
  logic [MAXF-1:0]  tag_we;
  logic [4:0]       tag_rd [MAXF];

  entry_t head;
  logic   full, empty, push, pop, cmp_hit;
  logic   raw_hazard, waw_hazard, tag_avail;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign in_ready_o = !full;
  // A push offered in a flush cycle is dropped along with the queue contents.
  assign push       = in_valid_i && !full && !flush_i;
  assign pop        = iss_valid_o && iss_ready_i;
  assign head       = mem[rd_ptr];

  // Completions of unallocated tags (including those wiped by reset) are ignored.
  assign cmp_hit  = cmp_valid_i && tag_valid[cmp_tag_i];
  assign cmp_we_o = cmp_hit && tag_we[cmp_tag_i];
  assign cmp_rd_o = cmp_hit ? tag_rd[cmp_tag_i] : 5'd0;

  assign iss_payload_o = head.payload;
  assign count_o       = count;
  assign busy_o        = (count != '0) || (inflight_o != '0);

  // Issue check: hazards and lowest free tag.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sb_view     = sb;
    free_view   = ~tag_valid;
    raw_hazard  = 1'b0;
    tag_avail   = 1'b0;
    iss_tag_o   = '0;
`ifdef FP_ISSUE_CMP_BYPASS_EN
    if (cmp_we_o) sb_view[cmp_rd_o] = 1'b0;
    if (cmp_hit)  free_view[cmp_tag_i] = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      if (head.rs_use[i] && sb_view[head.rs[5*i +: 5]]) raw_hazard = 1'b1;
    end
    waw_hazard = head.rd_we && sb_view[head.rd];
    // Scan downwards so the lowest free index is the last one written.
    for (int t = MAXF - 1; t >= 0; t--) begin
      if (free_view[t]) begin
        iss_tag_o = TAG_W'(t);
        tag_avail = 1'b1;
      end
    end
    iss_valid_o = !empty && !flush_i && !raw_hazard && !waw_hazard && tag_avail;
  end

  always_comb begin
    inflight_o = '0;
    for (int t = 0; t < MAXF; t++) inflight_o = inflight_o + (TAG_W+1)'(tag_valid[t]);
  end

  // Scoreboard / tag next state: clear on completion first, then set on
  // issue, so a tag freed and reallocated in one cycle ends up valid.
  always_comb begin
    // NOTE: blocking assignments here build the next state in order inside
    // combinational logic; the registers below take it with non-blocking ones.
    sb_next        = sb;
    tag_valid_next = tag_valid;
    if (cmp_hit)  tag_valid_next[cmp_tag_i] = 1'b0;
    if (cmp_we_o) sb_next[cmp_rd_o] = 1'b0;
    if (pop) begin
      tag_valid_next[iss_tag_o] = 1'b1;
      if (head.rd_we) sb_next[head.rd] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb        <= '0;
      tag_valid <= '0;
    end else begin
      sb        <= sb_next;
      tag_valid <= tag_valid_next;
    end
  end

  // NOTE: storage arrays carry no reset; each entry is only read after the
  // valid bit or occupancy count that guards it has been set.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{rs: in_rs_i, rs_use: in_rs_use_i, rd: in_rd_i,
                               rd_we: in_rd_we_i, payload: in_payload_i};
    if (pop) begin
      tag_rd[iss_tag_o] <= head.rd;
      tag_we[iss_tag_o] <= head.rd_we;
    end
  end

  // Queue pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb_fp_issue_ctrl
//   Randomized bench for fp_issue_ctrl. A reference model keeps the queue as
//   a list of operations and the in-flight work as a tag table; a register is
//   pending when some allocated tag writes it. Every cycle the model predicts
//   the DUT outputs from its state and the current inputs, then advances.
module tb_fp_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int PW    = 64;
  localparam int TAG_W = 2;
  localparam int MAXF  = 1 << TAG_W;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            in_valid_i, in_ready_o;
  logic [14:0]     in_rs_i;
  logic [2:0]      in_rs_use_i;
  logic [4:0]      in_rd_i;
  logic            in_rd_we_i;
  logic [PW-1:0]   in_payload_i;
  logic            flush_i;
  logic            iss_valid_o, iss_ready_i;
  logic [PW-1:0]   iss_payload_o;
  logic [TAG_W-1:0] iss_tag_o;
  logic            cmp_valid_i;
  logic [TAG_W-1:0] cmp_tag_i;
  logic [4:0]      cmp_rd_o;
  logic            cmp_we_o;
  logic [$clog2(DEPTH):0] count_o;
  logic [TAG_W:0]  inflight_o;
  logic            busy_o;

  fp_issue_ctrl #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_rs_i(in_rs_i), .in_rs_use_i(in_rs_use_i),
    .in_rd_i(in_rd_i), .in_rd_we_i(in_rd_we_i), .in_payload_i(in_payload_i),
    .flush_i(flush_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
    .iss_payload_o(iss_payload_o), .iss_tag_o(iss_tag_o),
    .cmp_valid_i(cmp_valid_i), .cmp_tag_i(cmp_tag_i),
    .cmp_rd_o(cmp_rd_o), .cmp_we_o(cmp_we_o),
    .count_o(count_o), .inflight_o(inflight_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [14:0]   rs;
    logic [2:0]    rs_use;
    logic [4:0]    rd;
    logic          we;
    logic [PW-1:0] payload;
  } op_t;

  op_t        q[$];
  bit         tag_busy [MAXF];
  logic [4:0] tag_rd   [MAXF];
  bit         tag_we   [MAXF];
  bit         view_busy[MAXF];

  function automatic bit pending(input logic [4:0] r);
    for (int i = 0; i < MAXF; i++)
      if (view_busy[i] && tag_we[i] && tag_rd[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < MAXF; i++) tag_busy[i] = 1'b0;
  endtask

  // Compare outputs for the current inputs, then advance the model by the
  // clock edge that follows.
  task automatic cycle_check();
    bit   hit, exp_we, exp_valid, fire;
    int   exp_tag, n_busy;
    op_t  h;
    hit    = cmp_valid_i && tag_busy[cmp_tag_i];
    exp_we = hit && tag_we[cmp_tag_i];
    n_busy = 0;
    for (int i = 0; i < MAXF; i++) begin
      view_busy[i] = tag_busy[i];
      if (tag_busy[i]) n_busy++;
    end
`ifdef FP_ISSUE_CMP_BYPASS_EN
    if (hit) view_busy[cmp_tag_i] = 1'b0;
`endif
    exp_tag = -1;
    for (int i = 0; i < MAXF; i++)
      if (!view_busy[i] && exp_tag < 0) exp_tag = i;
    exp_valid = 1'b0;
    if (q.size() > 0 && !flush_i && exp_tag >= 0) begin
      h = q[0];
      exp_valid = 1'b1;
      for (int s = 0; s < 3; s++)
        if (h.rs_use[s] && pending(h.rs[5*s +: 5])) exp_valid = 1'b0;
      if (h.we && pending(h.rd)) exp_valid = 1'b0;
    end

    check("in_ready", in_ready_o, q.size() < DEPTH);
    check("count",    count_o, q.size());
    check("inflight", inflight_o, n_busy);
    check("busy",     busy_o, (q.size() != 0) || (n_busy != 0));
    check("cmp_we",   cmp_we_o, exp_we);
    if (hit) check("cmp_rd", cmp_rd_o, tag_rd[cmp_tag_i]);
    check("iss_valid", iss_valid_o, exp_valid);
    if (exp_valid) begin
      check("iss_tag",     iss_tag_o, exp_tag);
      check("iss_payload", iss_payload_o, q[0].payload);
    end

    fire = exp_valid && iss_ready_i;
    if (hit) tag_busy[cmp_tag_i] = 1'b0;
    if (flush_i) q.delete();
    else begin
      if (in_valid_i && q.size() < DEPTH) begin
        if (fire) begin
          tag_busy[exp_tag] = 1'b1;
          tag_rd[exp_tag]   = q[0].rd;
          tag_we[exp_tag]   = q[0].we;
          void'(q.pop_front());
        end
        q.push_back('{rs: in_rs_i, rs_use: in_rs_use_i, rd: in_rd_i,
                      we: in_rd_we_i, payload: in_payload_i});
      end else if (fire) begin
        tag_busy[exp_tag] = 1'b1;
        tag_rd[exp_tag]   = q[0].rd;
        tag_we[exp_tag]   = q[0].we;
        void'(q.pop_front());
      end
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    in_valid_i = 0; in_rs_i = '0; in_rs_use_i = '0; in_rd_i = '0; in_rd_we_i = 0;
    in_payload_i = '0; flush_i = 0; iss_ready_i = 0; cmp_valid_i = 0; cmp_tag_i = '0;
  endtask

  task automatic drive_random(input int ready_pct, input int flush_pct);
    in_valid_i   = $urandom_range(0, 99) < 70;
    in_rs_i      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    in_rs_use_i  = 3'($urandom);
    in_rd_i      = 5'($urandom_range(0, 7));
    in_rd_we_i   = $urandom_range(0, 3) != 0;
    in_payload_i = {$urandom, $urandom};
    flush_i      = $urandom_range(0, 99) < flush_pct;
    iss_ready_i  = $urandom_range(0, 99) < ready_pct;
    cmp_valid_i  = $urandom_range(0, 99) < 35;
    cmp_tag_i    = TAG_W'($urandom);
  endtask

  task automatic run_phase(input int cycles, input int ready_pct, input int flush_pct);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_i); #1;
      drive_random(ready_pct, flush_pct);
      #3;
      cycle_check();
    end
  endtask

  // Asserts reset at the current time, checks the outputs react at once,
  // then releases between clock edges and checks in_ready afterwards.
  task automatic apply_reset();
    rst_ni = 1'b0;
    #1;
    check("rst_count",     count_o, 0);
    check("rst_inflight",  inflight_o, 0);
    check("rst_busy",      busy_o, 0);
    check("rst_iss_valid", iss_valid_o, 0);
    check("rst_cmp_we",    cmp_we_o, 0);
    check("rst_cmp_rd",    cmp_rd_o, 0);
    model_clear();
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check("rst_in_ready", in_ready_o, 1);
    #3;
    cycle_check();
  endtask

  initial begin
    idle_inputs();
    model_clear();
    #1;
    apply_reset();
    run_phase(1500, 70, 3);   // mixed traffic with occasional flush
    run_phase(400, 10, 0);    // mostly stalled: queue fills, full-push refusal
    run_phase(400, 95, 0);    // drain fast, tags saturate
    @(posedge clk_i); #2;     // reset mid-operation
    cmp_valid_i = 1'b1;
    apply_reset();
    run_phase(1200, 80, 5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
